lcd_byte_scheduler: RTL and testbench

- Post-initialisation LCD write scheduler. Shares the 4-bit LCD nibble transfer engine between two byte requesters using round-robin arbitration.
- Splits each accepted byte (command or data) into high and low nibble transfers.
- Attaches the required post-nibble delay to each nibble: fixed for the high nibble; for the low nibble, 3 ms for clear/home commands and 53 µs otherwise.
- Sits between the init sequencer (its done flag gates operation) and the nibble transfer engine.

---
 rtl/lcd_byte_scheduler.sv | 127 ++++++++++++
 tb/tb_lcd_byte_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_scheduler.sv
// lcd_byte_scheduler: shares the 4-bit LCD nibble engine between two byte
// requesters with round-robin arbitration. Each accepted byte goes out as a
// high nibble and then a low nibble, each tagged with its post-nibble delay.
//
// Handshake: a requester holds reqN_valid with rs/data stable until it sees
// reqN_ready high in the same cycle. valid & ready on a rising edge transfers
// the byte. Ready is a combinational function of valid, so it may only be
// sampled, never used to form valid. Towards the engine, xfer_send is a
// one-cycle start strobe with xfer_command/xfer_delay valid alongside it.
// xfer_done is a one-cycle completion strobe that counts only in WAIT_HI and
// WAIT_LO.
module lcd_byte_scheduler #(
    parameter int FREQ      = 50000000,
    parameter int T_NIB_US  = 10,
    parameter int T_CMD_US  = 53,
    parameter int T_LONG_US = 3000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        init_done,
    input  logic        req0_valid,
    input  logic        req0_rs,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_rs,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        xfer_send,
    output logic [4:0]  xfer_command,
    output logic [20:0] xfer_delay,
    input  logic        xfer_done,
    output logic        busy,
    output logic        last_grant,
    output logic [2:0]  fsm_state
);

    localparam int CYC_PER_US = FREQ / 1000000;
    localparam logic [20:0] D_NIB  = 21'(CYC_PER_US * T_NIB_US);
    localparam logic [20:0] D_CMD  = 21'(CYC_PER_US * T_CMD_US);
    localparam logic [20:0] D_LONG = 21'(CYC_PER_US * T_LONG_US);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE_HI = 3'd1;
    localparam logic [2:0] S_WAIT_HI  = 3'd2;
    localparam logic [2:0] S_ISSUE_LO = 3'd3;
    localparam logic [2:0] S_WAIT_LO  = 3'd4;

    logic [2:0] state;
    logic       grant;
    logic       can_accept;
    logic       accept;
    logic       sel_rs;
    logic [7:0] sel_data;
    logic       rs_q;
    logic [7:0] data_q;
    logic       long_wait;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign can_accept = (state == S_IDLE) && init_done;
    assign req0_ready = can_accept && req0_valid && !grant;
    assign req1_ready = can_accept && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign sel_rs     = grant ? req1_rs : req0_rs;
    assign sel_data   = grant ? req1_data : req0_data;

    // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
    assign long_wait = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    // Byte FSM; the engine outputs are loaded on the edge entering an ISSUE state
    // so they are registered and valid during the xfer_send cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            xfer_send    <= 1'b0;
            xfer_command <= 5'd0;
            xfer_delay   <= 21'd0;
            last_grant   <= 1'b1;
            rs_q         <= 1'b0;
            data_q       <= 8'd0;
        end else begin
            xfer_send <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        rs_q         <= sel_rs;
                        data_q       <= sel_data;
                        last_grant   <= grant;
                        xfer_send    <= 1'b1;
                        xfer_command <= {sel_rs, sel_data[7:4]};
                        xfer_delay   <= D_NIB;
                        state        <= S_ISSUE_HI;
                    end
                end
                S_ISSUE_HI: state <= S_WAIT_HI;
                S_WAIT_HI: begin
                    if (xfer_done) begin
                        xfer_send    <= 1'b1;
                        xfer_command <= {rs_q, data_q[3:0]};
                        xfer_delay   <= long_wait ? D_LONG : D_CMD;
                        state        <= S_ISSUE_LO;
                    end
                end
                S_ISSUE_LO: state <= S_WAIT_LO;
                S_WAIT_LO: begin
                    if (xfer_done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_byte_scheduler.sv
// Directed bench for lcd_byte_scheduler: arbitration, nibble split, delays,
// stray completion strobes, init_done gating and mid-byte reset.
module tb_lcd_byte_scheduler;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_HI = 3'd2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        init_done = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_rs = 1'b0;
    logic [7:0]  req0_data = 8'd0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic        req1_rs = 1'b0;
    logic [7:0]  req1_data = 8'd0;
    logic        req1_ready;
    logic        xfer_send;
    logic [4:0]  xfer_command;
    logic [20:0] xfer_delay;
    logic        xfer_done = 1'b0;
    logic        busy;
    logic        last_grant;
    logic [2:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_byte_scheduler dut (
        .CLK(CLK), .RESET(RESET), .init_done(init_done),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .xfer_send(xfer_send), .xfer_command(xfer_command), .xfer_delay(xfer_delay),
        .xfer_done(xfer_done), .busy(busy), .last_grant(last_grant), .fsm_state(fsm_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a byte on requester idx, check ready, and let it be accepted.
    task automatic accept_byte(input int idx, input logic rs, input logic [7:0] data, input string tag);
        if (idx == 0) begin
            req0_valid = 1'b1; req0_rs = rs; req0_data = data;
        end else begin
            req1_valid = 1'b1; req1_rs = rs; req1_data = data;
        end
        #1;
        chk({tag, "_ready0"}, 32'(req0_ready), 32'(idx == 0));
        chk({tag, "_ready1"}, 32'(req1_ready), 32'(idx == 1));
        tick();
        // Requester inputs scrambled after acceptance must not leak into the byte.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'($urandom_range(0, 255)); req1_data = 8'($urandom_range(0, 255));
        req0_rs = 1'($urandom_range(0, 1)); req1_rs = 1'($urandom_range(0, 1));
        chk({tag, "_last_grant"}, 32'(last_grant), 32'(idx));
    endtask

    // Called in the ISSUE_HI cycle: checks both nibbles with a 3-cycle engine model.
    task automatic run_nibbles(input logic [4:0] hi_cmd, input logic [20:0] hi_d,
                               input logic [4:0] lo_cmd, input logic [20:0] lo_d, input string tag);
        chk({tag, "_hi_send"}, 32'(xfer_send), 32'd1);
        chk({tag, "_hi_cmd"}, 32'(xfer_command), 32'(hi_cmd));
        chk({tag, "_hi_delay"}, 32'(xfer_delay), 32'(hi_d));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        tick(); tick();
        chk({tag, "_hi_held"}, 32'({xfer_send, xfer_command}), 32'({1'b0, hi_cmd}));
        tick();
        xfer_done = 1'b1; tick(); xfer_done = 1'b0;
        chk({tag, "_lo_send"}, 32'(xfer_send), 32'd1);
        chk({tag, "_lo_cmd"}, 32'(xfer_command), 32'(lo_cmd));
        chk({tag, "_lo_delay"}, 32'(xfer_delay), 32'(lo_d));
        tick(); tick(); tick();
        chk({tag, "_lo_wait"}, 32'({busy, xfer_send}), 32'b10);
        xfer_done = 1'b1; tick(); xfer_done = 1'b0;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_state"}, 32'(fsm_state), 32'(S_IDLE));
    endtask

    // Directed sequence
    initial begin
        // Reset with init_done low and a pending request
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        tick(); tick();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gated_ready0", 32'(req0_ready), 32'd0);
            chk("gated_send", 32'(xfer_send), 32'd0);
        end
        chk("rst_last_grant", 32'(last_grant), 32'd1);
        chk("rst_cmd", 32'(xfer_command), 32'd0);
        chk("rst_delay", 32'(xfer_delay), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req0_valid = 1'b0;

        // Single bytes and delay selection
        init_done = 1'b1;
        accept_byte(0, 1'b1, 8'h41, "d41");
        run_nibbles(5'h14, 21'd500, 5'h11, 21'd2650, "d41");
        accept_byte(1, 1'b0, 8'h01, "clr");
        run_nibbles(5'h00, 21'd500, 5'h01, 21'd150000, "clr");
        accept_byte(1, 1'b1, 8'h01, "d01");
        run_nibbles(5'h10, 21'd500, 5'h11, 21'd2650, "d01");
        accept_byte(0, 1'b0, 8'h03, "home");
        run_nibbles(5'h00, 21'd500, 5'h03, 21'd150000, "home");
        accept_byte(0, 1'b0, 8'h04, "c04");
        run_nibbles(5'h00, 21'd500, 5'h04, 21'd2650, "c04");

        // Round-robin with both requesters holding valid from reset
        RESET = 1'b1; tick(); RESET = 1'b0;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h30;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h31;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("rr_ready1", 32'(req1_ready), 32'(i % 2 == 1));
            tick();
            chk("rr_last_grant", 32'(last_grant), 32'(i % 2));
            chk("rr_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
            run_nibbles(5'h13, 21'd500, (i % 2 == 0) ? 5'h10 : 5'h11, 21'd2650, "rr");
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Stray xfer_done in IDLE, then in ISSUE_HI
        xfer_done = 1'b1; tick(); xfer_done = 1'b0;
        chk("stray_idle_state", 32'(fsm_state), 32'(S_IDLE));
        chk("stray_idle_send", 32'(xfer_send), 32'd0);
        accept_byte(0, 1'b1, 8'h5A, "stray");
        xfer_done = 1'b1; tick(); xfer_done = 1'b0;
        chk("stray_hi_state", 32'(fsm_state), 32'(S_WAIT_HI));
        chk("stray_hi_send", 32'(xfer_send), 32'd0);
        tick(); tick();
        chk("stray_hi_hold", 32'({fsm_state, xfer_send}), 32'({S_WAIT_HI, 1'b0}));
        xfer_done = 1'b1; tick(); xfer_done = 1'b0;
        chk("stray_lo_cmd", 32'({xfer_send, xfer_command}), 32'({1'b1, 5'h1A}));
        tick(); xfer_done = 1'b1; tick(); xfer_done = 1'b0;
        chk("stray_done_idle", 32'(fsm_state), 32'(S_IDLE));

        // init_done falling mid-byte: byte completes, nothing further accepted
        accept_byte(1, 1'b0, 8'h80, "fall");
        init_done = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        run_nibbles(5'h08, 21'd500, 5'h00, 21'd2650, "fall");
        tick();
        chk("fall_ready", 32'({req0_ready, req1_ready}), 32'd0);
        chk("fall_send", 32'(xfer_send), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        init_done = 1'b1;

        // Reset in WAIT_HI, then a fresh request
        accept_byte(1, 1'b1, 8'hC7, "mid");
        tick();
        chk("mid_wait_hi", 32'(fsm_state), 32'(S_WAIT_HI));
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk("mid_state", 32'(fsm_state), 32'(S_IDLE));
        chk("mid_send", 32'(xfer_send), 32'd0);
        chk("mid_last_grant", 32'(last_grant), 32'd1);
        chk("mid_outputs", 32'({busy, xfer_command, xfer_delay}), 32'd0);
        xfer_done = 1'b1; tick(); xfer_done = 1'b0;
        tick();
        chk("mid_no_lo", 32'({xfer_send, fsm_state}), 32'd0);
        accept_byte(0, 1'b0, 8'h02, "fresh");
        run_nibbles(5'h00, 21'd500, 5'h02, 21'd150000, "fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
